// File: rtl/ray_pkg.sv
// rtl/ray_pkg.sv - shared types and helpers for the ray scheduler
//
// Purpose: slot and scheduler state encodings, colour width, round-robin
// pointer helper shared by ray_scheduler and its arbiters.
package ray_pkg;

  localparam int COLOR_BITS = 4;

  // Per-core bookkeeping: a core is only handed a new pixel from FREE.
  typedef enum logic [1:0] {
    FREE  = 2'd0,
    ARMED = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } slot_state_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2,
    S_DONE     = 2'd3
  } sched_state_t;

  // Index that follows idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin one-hot arbiter
//
// Purpose: grant the first requester at or after ptr, wrapping around.
// Ports:
//   req       in  N   request vector
//   ptr       in  PW  index where the search starts
//   grant     out N   one-hot grant (zero when no request)
//   grant_idx out PW  binary index of the granted requester
//   any       out 1   a grant was issued
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  // Outer loop walks the search order, inner loop maps the rotated position
  // back onto a constant index so every select stays static.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!any && req[j] && (((int'(ptr) + i) % N) == j)) begin
          grant[j]  = 1'b1;
          grant_idx = PW'(j);
          any       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ray_scheduler.sv
// rtl/ray_scheduler.sv - frame scheduler sharing ray_unit cores across pixels
//
// Purpose: walk the frame in raster order, hand each pixel to a free core,
// collect finished results one per cycle onto a single write port.
// Ports:
//   clk_in, rst_in          clock, synchronous active-high reset
//   start_in                frame start pulse (honoured only when idle)
//   busy_out                frame in progress
//   frame_done_out          one-cycle pulse once every result is written
//   core_valid_out          one-hot dispatch strobe
//   core_hcount/vcount_out  pixel broadcast with the strobe
//   core_ready_in           per-core idle flag, result held valid
//   core_hcount/vcount/color_in  packed per-core results
//   wr_valid/hcount/vcount/color_out  result write toward the frame buffer
module ray_scheduler
  import ray_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int DISPLAY_WIDTH  = 320,
  parameter int DISPLAY_HEIGHT = 180,
  parameter int H_BITS         = 9,
  parameter int V_BITS         = 8
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            start_in,
  output logic                            busy_out,
  output logic                            frame_done_out,
  output logic [NUM_CORES-1:0]            core_valid_out,
  output logic [H_BITS-1:0]               core_hcount_out,
  output logic [V_BITS-1:0]               core_vcount_out,
  input  logic [NUM_CORES-1:0]            core_ready_in,
  input  logic [NUM_CORES*H_BITS-1:0]     core_hcount_in,
  input  logic [NUM_CORES*V_BITS-1:0]     core_vcount_in,
  input  logic [NUM_CORES*COLOR_BITS-1:0] core_color_in,
  output logic                            wr_valid_out,
  output logic [H_BITS-1:0]               wr_hcount_out,
  output logic [V_BITS-1:0]               wr_vcount_out,
  output logic [COLOR_BITS-1:0]           wr_color_out
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  sched_state_t state, state_next;
  slot_state_t  slot [NUM_CORES];

  logic [H_BITS-1:0] h_cnt;
  logic [V_BITS-1:0] v_cnt;
  logic [PW-1:0]     disp_ptr, wr_ptr;

  logic [NUM_CORES-1:0] free_req, done_req, disp_grant, wr_grant;
  logic [PW-1:0]        disp_idx, wr_idx;
  logic                 disp_any, wr_any;
  logic                 dispatch_fire, last_pixel, all_free;

  logic                  busy_d, done_d;
  logic [NUM_CORES-1:0]  core_valid_d;
  logic [H_BITS-1:0]     sel_h;
  logic [V_BITS-1:0]     sel_v;
  logic [COLOR_BITS-1:0] sel_c;

  always_comb begin
    free_req = '0;
    done_req = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      free_req[i] = (slot[i] == FREE);
      done_req[i] = (slot[i] == DONE);
    end
  end

  assign all_free      = &free_req;
  assign last_pixel    = (h_cnt == H_BITS'(DISPLAY_WIDTH - 1)) &&
                         (v_cnt == V_BITS'(DISPLAY_HEIGHT - 1));
  assign dispatch_fire = (state == S_DISPATCH) && disp_any;

  rr_arbiter #(.N(NUM_CORES)) u_disp_arb (
    .req       (free_req),
    .ptr       (disp_ptr),
    .grant     (disp_grant),
    .grant_idx (disp_idx),
    .any       (disp_any)
  );

  rr_arbiter #(.N(NUM_CORES)) u_wr_arb (
    .req       (done_req),
    .ptr       (wr_ptr),
    .grant     (wr_grant),
    .grant_idx (wr_idx),
    .any       (wr_any)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (start_in) state_next = S_DISPATCH;
      S_DISPATCH: if (dispatch_fire && last_pixel) state_next = S_DRAIN;
      // A registered write still on wr_* counts as in flight.
      S_DRAIN:    if (all_free && !wr_valid_out) state_next = S_DONE;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Next values for the registered status/strobe outputs.
  always_comb begin
    busy_d       = (state_next == S_DISPATCH) || (state_next == S_DRAIN);
    done_d       = (state_next == S_DONE);
    core_valid_d = dispatch_fire ? disp_grant : '0;
  end

  always_comb begin
    sel_h = '0;
    sel_v = '0;
    sel_c = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (wr_grant[i]) begin
        sel_h = core_hcount_in[i*H_BITS +: H_BITS];
        sel_v = core_vcount_in[i*V_BITS +: V_BITS];
        sel_c = core_color_in[i*COLOR_BITS +: COLOR_BITS];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_out        <= 1'b0;
      frame_done_out  <= 1'b0;
      core_valid_out  <= '0;
      core_hcount_out <= '0;
      core_vcount_out <= '0;
      wr_valid_out    <= 1'b0;
      wr_hcount_out   <= '0;
      wr_vcount_out   <= '0;
      wr_color_out    <= '0;
      h_cnt           <= '0;
      v_cnt           <= '0;
      disp_ptr        <= '0;
      wr_ptr          <= '0;
      for (int i = 0; i < NUM_CORES; i++) slot[i] <= FREE;
    end else begin
      busy_out       <= busy_d;
      frame_done_out <= done_d;
      core_valid_out <= core_valid_d;
      wr_valid_out   <= wr_any;

      if (state == S_IDLE && start_in) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (dispatch_fire) begin
        core_hcount_out <= h_cnt;
        core_vcount_out <= v_cnt;
        disp_ptr        <= PW'(rr_next(int'(disp_idx), NUM_CORES));
        if (h_cnt == H_BITS'(DISPLAY_WIDTH - 1)) begin
          h_cnt <= '0;
          v_cnt <= v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end

      if (wr_any) begin
        wr_hcount_out <= sel_h;
        wr_vcount_out <= sel_v;
        wr_color_out  <= sel_c;
        wr_ptr        <= PW'(rr_next(int'(wr_idx), NUM_CORES));
      end

      // ARMED ignores core_ready_in: the core still shows its previous
      // result during the strobe cycle.
      for (int i = 0; i < NUM_CORES; i++) begin
        case (slot[i])
          FREE:    if (dispatch_fire && disp_grant[i]) slot[i] <= ARMED;
          ARMED:   slot[i] <= BUSY;
          BUSY:    if (core_ready_in[i]) slot[i] <= DONE;
          DONE:    if (wr_grant[i]) slot[i] <= FREE;
          default: slot[i] <= FREE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ray_scheduler.sv
// tb/tb_ray_scheduler.sv - self-checking bench for ray_scheduler
module tb_ray_scheduler;

  localparam int NC = 4, W = 5, H = 3, HB = 9, VB = 8, NPIX = W * H;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start1 = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] colf(input int h, input int v, input int c);
    return 4'((h * 3 + v * 5 + c * 7) & 15);
  endfunction

  // ---------------- four-core DUT ----------------
  logic busy, fdone, wval;
  logic [NC-1:0] cvalid, crdy;
  logic [HB-1:0] chc, wh;
  logic [VB-1:0] cvc, wv;
  logic [3:0] wc;
  logic [NC*HB-1:0] chin;
  logic [NC*VB-1:0] cvin;
  logic [NC*4-1:0] ccin;

  ray_scheduler #(.NUM_CORES(NC), .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H),
                  .H_BITS(HB), .V_BITS(VB)) u_dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .busy_out(busy),
    .frame_done_out(fdone), .core_valid_out(cvalid), .core_hcount_out(chc),
    .core_vcount_out(cvc), .core_ready_in(crdy), .core_hcount_in(chin),
    .core_vcount_in(cvin), .core_color_in(ccin), .wr_valid_out(wval),
    .wr_hcount_out(wh), .wr_vcount_out(wv), .wr_color_out(wc)
  );

  // Core models: ready drops after a strobe, returns lat cycles later.
  int lat [NC];
  int cnt [NC];
  logic [HB-1:0] ph [NC];
  logic [HB-1:0] rh [NC];
  logic [VB-1:0] pv [NC];
  logic [VB-1:0] rv [NC];
  logic [3:0]    rc [NC];

  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (rst) begin
        crdy[i] <= 1'b1; cnt[i] <= 0; rh[i] <= '0; rv[i] <= '0; rc[i] <= '0;
      end else if (cvalid[i]) begin
        crdy[i] <= 1'b0; cnt[i] <= lat[i]; ph[i] <= chc; pv[i] <= cvc;
      end else if (!crdy[i]) begin
        if (cnt[i] <= 1) begin
          crdy[i] <= 1'b1; rh[i] <= ph[i]; rv[i] <= pv[i];
          rc[i] <= colf(int'(ph[i]), int'(pv[i]), i);
        end else cnt[i] <= cnt[i] - 1;
      end
    end
  end

  always_comb begin
    chin = '0; cvin = '0; ccin = '0;
    for (int i = 0; i < NC; i++) begin
      chin[i*HB +: HB] = rh[i];
      cvin[i*VB +: VB] = rv[i];
      ccin[i*4 +: 4]   = rc[i];
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  logic phase_m = 1'b0;
  logic [NC-1:0] occ_m = '0, exp_valid = '0;
  int ptr_m = 0, disp_cnt = 0, wr_cnt = 0, done_cnt = 0, prev_p = -1, ooo = 0;
  int core_of [NPIX];
  int written [NPIX];
  int log_h[$], log_v[$], log_c[$], log_cyc[$];
  int k, p, once;

  task automatic clear_frame();
    disp_cnt = 0; wr_cnt = 0; prev_p = -1; ooo = 0;
    for (int i = 0; i < NPIX; i++) begin core_of[i] = -1; written[i] = 0; end
    log_h.delete(); log_v.delete(); log_c.delete(); log_cyc.delete();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      phase_m = 1'b0; occ_m = '0; exp_valid = '0; ptr_m = 0;
      clear_frame();
    end else begin
      chk("busy", busy, phase_m && !fdone);
      chk("dispatch_strobe", cvalid, exp_valid);
      if (cvalid != '0) begin
        k = -1;
        for (int i = 0; i < NC; i++) if (cvalid[i] && k < 0) k = i;
        chk("slot_free", occ_m[k], 0);
        chk("disp_h", chc, disp_cnt % W);
        chk("disp_v", cvc, disp_cnt / W);
        if (disp_cnt < NPIX) core_of[disp_cnt] = k;
        occ_m[k] = 1'b1; ptr_m = (k + 1) % NC; disp_cnt++;
      end
      if (wval) begin
        if (wh < W && wv < H) begin
          p = int'(wv) * W + int'(wh);
          chk("wr_outstanding", (core_of[p] >= 0) && (written[p] == 0), 1);
          if (core_of[p] >= 0) begin
            chk("wr_color", wc, colf(int'(wh), int'(wv), core_of[p]));
            occ_m[core_of[p]] = 1'b0;
          end
          if (p < prev_p) ooo = 1;
          prev_p = p; written[p]++;
        end else chk("wr_coord_range", 0, 1);
        log_h.push_back(int'(wh)); log_v.push_back(int'(wv));
        log_c.push_back(int'(wc)); log_cyc.push_back(cyc);
        wr_cnt++;
      end
      if (fdone) begin
        chk("done_expected", phase_m, 1);
        chk("done_wr_cnt", wr_cnt, NPIX);
        chk("done_disp_cnt", disp_cnt, NPIX);
        chk("done_after_last_wr", wval, 0);
        once = 0;
        for (int i = 0; i < NPIX; i++) if (written[i] == 1) once++;
        chk("each_pixel_once", once, NPIX);
        done_cnt++; phase_m = 1'b0;
      end
      exp_valid = '0;
      if (phase_m && disp_cnt < NPIX)
        for (int i = 0; i < NC; i++)
          if (exp_valid == '0 && !occ_m[(ptr_m + i) % NC]) exp_valid[(ptr_m + i) % NC] = 1'b1;
      if (!phase_m && start) begin
        phase_m = 1'b1;
        clear_frame();
      end
    end
  end

  // ---------------- single-core DUT ----------------
  logic busy1, fdone1, cvalid1, crdy1, wval1;
  logic [HB-1:0] chc1, wh1, rh1, ph1;
  logic [VB-1:0] cvc1, wv1, rv1, pv1;
  logic [3:0] wc1, rc1;
  int cnt1, d1 = 0, w1 = 0, done1 = 0;

  ray_scheduler #(.NUM_CORES(1), .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H),
                  .H_BITS(HB), .V_BITS(VB)) u_dut1 (
    .clk_in(clk), .rst_in(rst), .start_in(start1), .busy_out(busy1),
    .frame_done_out(fdone1), .core_valid_out(cvalid1), .core_hcount_out(chc1),
    .core_vcount_out(cvc1), .core_ready_in(crdy1), .core_hcount_in(rh1),
    .core_vcount_in(rv1), .core_color_in(rc1), .wr_valid_out(wval1),
    .wr_hcount_out(wh1), .wr_vcount_out(wv1), .wr_color_out(wc1)
  );

  always @(posedge clk) begin
    if (rst) begin
      crdy1 <= 1'b1; cnt1 <= 0; rh1 <= '0; rv1 <= '0; rc1 <= '0;
    end else if (cvalid1) begin
      crdy1 <= 1'b0; cnt1 <= 4; ph1 <= chc1; pv1 <= cvc1;
    end else if (!crdy1) begin
      if (cnt1 <= 1) begin
        crdy1 <= 1'b1; rh1 <= ph1; rv1 <= pv1; rc1 <= colf(int'(ph1), int'(pv1), 0);
      end else cnt1 <= cnt1 - 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (start1 && !busy1) begin d1 = 0; w1 = 0; end
      if (cvalid1) begin
        chk("s1_serialized", d1 == w1, 1);
        chk("s1_disp_h", chc1, d1 % W);
        chk("s1_disp_v", cvc1, d1 / W);
        d1++;
      end
      if (wval1) begin
        chk("s1_wr_h", wh1, w1 % W);
        chk("s1_wr_v", wv1, w1 / W);
        chk("s1_wr_color", wc1, colf(w1 % W, w1 / W, 0));
        w1++;
      end
      if (fdone1) begin
        chk("s1_done_disp", d1, NPIX);
        chk("s1_done_wr", w1, NPIX);
        done1++;
      end
    end
  end

  // ---------------- directed sequence ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    chk(nm, {busy, fdone, cvalid, chc, cvc, wval, wh, wv, wc}, 0);
    chk({nm, "_single"}, {busy1, fdone1, cvalid1, chc1, cvc1, wval1, wh1, wv1, wc1}, 0);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 3000) begin @(posedge clk); n++; end
    chk("frame_done_timeout", done_cnt >= target, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    for (int i = 0; i < NC; i++) lat[i] = 10;
    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", {busy, fdone, cvalid, chc, cvc, wval, wh, wv, wc}, 0);
    rst = 1'b0;

    // Fixed 10-cycle cores: first strobe one cycle after start at (0,0).
    pulse_start();
    @(posedge clk); #1;
    chk("first_strobe", cvalid, 4'b0001);
    chk("first_h", chc, 0);
    chk("first_v", cvc, 0);
    chk("first_busy", busy, 1);
    wait_done(1);
    chk("t1_writes", log_h.size(), NPIX);
    chk("t1_busy_fell", busy, 0);
    chk("t1_done_once", done_cnt, 1);

    // Latencies chosen so all four cores go ready in the same cycle.
    do_reset("reset_t2");
    for (int i = 0; i < NC; i++) lat[i] = 13 - i;
    pulse_start();
    wait_done(2);
    for (int i = 0; i < NC; i++) begin
      chk("burst_h", log_h[i], i);
      chk("burst_v", log_v[i], 0);
      chk("burst_color", log_c[i], colf(i, 0, i));
      if (i > 0) chk("burst_consecutive", log_cyc[i] - log_cyc[i-1], 1);
    end

    // Mixed latencies: results leave out of raster order.
    do_reset("reset_t3");
    lat[0] = 3; lat[1] = 17; lat[2] = 5; lat[3] = 29;
    pulse_start();
    wait_done(3);
    chk("t3_out_of_order", ooo, 1);
    chk("t3_writes", log_h.size(), NPIX);

    // Second start while busy is ignored.
    do_reset("reset_t4");
    for (int i = 0; i < NC; i++) lat[i] = 10;
    pulse_start();
    repeat (6) @(posedge clk);
    pulse_start();
    wait_done(4);
    chk("t4_writes", log_h.size(), NPIX);
    repeat (30) @(posedge clk); #1;
    chk("t4_no_extra_frame", done_cnt, 4);
    chk("t4_idle", busy, 0);

    // Reset mid-dispatch aborts without a done pulse.
    pulse_start();
    repeat (4) @(posedge clk);
    base = done_cnt;
    do_reset("reset_mid_frame");
    repeat (40) @(posedge clk); #1;
    chk("abort_no_done", done_cnt, base);
    pulse_start();
    wait_done(base + 1);
    chk("t5_writes", log_h.size(), NPIX);

    // Single core: strictly serialized.
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int n = 0; n < 3000 && done1 == 0; n++) @(posedge clk);
    #1;
    chk("s1_done", done1, 1);
    chk("s1_total_writes", w1, NPIX);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
